// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and Wishbone widths for the BRAM arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
  localparam int dw = 32;
  localparam int sw = 4;
endpackage

// File: rtl/bram_arb_wdog.sv
// bram_arb_wdog: counts stalled strobe cycles and flags err for one cycle at the limit
module bram_arb_wdog #(
  parameter int timeout = 16,
  parameter int tmr_width = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clr,
  output logic err
);
  localparam logic [tmr_width:0] lim = (tmr_width+1)'(timeout - 1);
  localparam logic [tmr_width:0] one = (tmr_width+1)'(1);
  logic [tmr_width-1:0] cnt;
  logic [tmr_width:0] cur;
  // cur includes the present stalled cycle
  assign cur = {1'b0, cnt} + one;
  assign err = (timeout != 0) && stall && (cur >= lim);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !stall || err) ? '0 : cur[tmr_width-1:0];
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-master Wishbone arbiter for one BRAM slave
module bram_arbiter import bram_arb_pkg::*; #(
  parameter int timeout = 16,
  parameter int tmr_width = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [dw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [sw-1:0] m0_sel_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [dw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [sw-1:0] m1_sel_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [dw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [sw-1:0] s_sel_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i
);
  state_t state, nxt;
  logic last, g0, g1, stb, stall, err;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      last <= 1'b1;
    end else begin
      state <= nxt;
      if (state != IDLE && nxt != state) last <= (state == GNT1);
    end
  // release is resolved before the round-robin pick, so handover skips IDLE
  always_comb begin
    nxt = state;
    if (state == GNT0) nxt = m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (state == GNT1) nxt = m1_cyc_i ? GNT1 : m0_cyc_i ? GNT0 : IDLE;
    else nxt = (m0_cyc_i && m1_cyc_i) ? (last ? GNT0 : GNT1) : m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
  end
  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);
  assign stb = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = stb & ~err;
  assign s_we_o = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign stall = s_cyc_o & stb & ~s_ack_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & err;
  assign m1_err_o = g1 & err;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;
  bram_arb_wdog #(.timeout(timeout), .tmr_width(tmr_width)) u_wdog (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .stall(stall),
    .clr(nxt != state),
    .err(err)
  );
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed scenarios plus randomized traffic against a cycle model
module tb_bram_arbiter;
  localparam int to = 16;
  logic clk = 1'b0, rst_n;
  logic cyc[2], stb[2], we[2];
  logic [31:0] adr[2], wdat[2];
  logic [3:0] sel[2];
  logic [31:0] sdat;
  logic sack;
  logic [31:0] m0_dat, m1_dat, s_adr, s_dat;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0] s_sel;
  logic [138:0] got;
  int pass = 0, total = 0;

  bram_arbiter #(.timeout(to), .tmr_width(8)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_sel_o(s_sel), .s_dat_i(sdat), .s_ack_i(sack)
  );

  always #5 clk = ~clk;
  assign got = {s_cyc, s_stb, s_we, s_adr, s_dat, s_sel, m0_dat, m0_ack, m0_err, m1_dat, m1_ack, m1_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; wdat[i] = '0; sel[i] = '0;
    end
    sdat = '0; sack = 0;
  endtask

  task automatic rnd_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'($urandom); stb[i] = 1'($urandom); we[i] = 1'($urandom);
      adr[i] = $urandom; wdat[i] = $urandom; sel[i] = 4'($urandom);
    end
    sdat = $urandom; sack = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      rnd_inputs();
      #3;
      total++; if (got !== '0) $display("FAIL reset_outputs: got=%h want 0", got); else pass++;
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_read();
    tick();
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h10;
    @(negedge clk);
    total++; if (s_cyc !== 1'b0) $display("FAIL read_latency: s_cyc=%b want 0", s_cyc); else pass++;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h10}) $display("FAIL read_grant: cyc/adr=%b/%h want 1/00000010", s_cyc, s_adr); else pass++;
    tick();
    sack = 1; sdat = 32'hA5A5_1234;
    @(negedge clk);
    total++; if ({m0_ack, m0_dat} !== {1'b1, 32'hA5A5_1234}) $display("FAIL read_ack: ack/dat=%b/%h want 1/a5a51234", m0_ack, m0_dat); else pass++;
    tick();
    sack = 0; cyc[0] = 0; stb[0] = 0;
    @(negedge clk);
    total++; if (s_cyc !== 1'b0) $display("FAIL read_release: s_cyc=%b want 0", s_cyc); else pass++;
  endtask

  task automatic test_tie();
    do_reset();
    tick();
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h100;
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h200;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h100}) $display("FAIL tie_first: cyc/adr=%b/%h want 1/00000100", s_cyc, s_adr); else pass++;
    tick();
    cyc[0] = 0; stb[0] = 0;
    @(negedge clk);
    total++; if (s_cyc !== 1'b0) $display("FAIL tie_drop: s_cyc=%b want 0", s_cyc); else pass++;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h200}) $display("FAIL tie_handover: cyc/adr=%b/%h want 1/00000200", s_cyc, s_adr); else pass++;
    tick();
    cyc[1] = 0; stb[1] = 0;
    tick();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h100}) $display("FAIL tie_alternate: cyc/adr=%b/%h want 1/00000100", s_cyc, s_adr); else pass++;
    tick();
    cyc[0] = 0; stb[0] = 0; cyc[1] = 0; stb[1] = 0;
    tick();
  endtask

  task automatic test_isolation();
    tick();
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h20; wdat[1] = 32'hDEADBEEF; sel[1] = 4'b0011;
    cyc[0] = 1; stb[0] = 1; adr[0] = 32'h300;
    for (int k = 0; k < 6; k++) begin
      tick();
      sack = (k % 2 == 1);
      @(negedge clk);
      total++;
      if ({s_cyc, s_we, s_adr, s_dat, s_sel, m0_ack, m1_ack} !== {2'b11, 32'h20, 32'hDEADBEEF, 4'b0011, 1'b0, sack})
        $display("FAIL isolation: we/adr/dat/sel/ack0/ack1=%b/%h/%h/%b/%b/%b want 1/00000020/deadbeef/0011/0/%b",
                 s_we, s_adr, s_dat, s_sel, m0_ack, m1_ack, sack);
      else pass++;
    end
    tick();
    sack = 0; cyc[1] = 0; stb[1] = 0; we[1] = 0;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h300}) $display("FAIL isolation_handover: cyc/adr=%b/%h want 1/00000300", s_cyc, s_adr); else pass++;
    tick();
    cyc[0] = 0; stb[0] = 0;
    tick();
  endtask

  task automatic test_watchdog();
    tick();
    cyc[0] = 1; stb[0] = 1; sack = 0;
    for (int k = 1; k <= 40; k++) begin
      logic e;
      tick();
      e = (k % (to - 1) == 0);
      @(negedge clk);
      total++;
      if ({m0_err, s_stb} !== {e, ~e}) $display("FAIL watchdog cycle %0d: err/stb=%b/%b want %b/%b", k, m0_err, s_stb, e, ~e);
      else pass++;
    end
    tick();
    cyc[0] = 0; stb[0] = 0;
    tick();
  endtask

  task automatic test_collision();
    tick();
    cyc[0] = 1; stb[0] = 1; sack = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      sack = (k == to - 1);
      @(negedge clk);
      if (k >= to - 1) begin
        total++;
        if ({m0_ack, m0_err} !== {sack, 1'b0}) $display("FAIL collision cycle %0d: ack/err=%b/%b want %b/0", k, m0_ack, m0_err, sack);
        else pass++;
      end
    end
    tick();
    sack = 0; cyc[0] = 0; stb[0] = 0;
    tick();
  endtask

  task automatic test_midreset();
    tick();
    cyc[1] = 1; stb[1] = 1; adr[1] = 32'h55;
    tick();
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h55}) $display("FAIL midreset_grant1: cyc/adr=%b/%h want 1/00000055", s_cyc, s_adr); else pass++;
    #2;
    rst_n = 0;
    #1;
    total++; if (got !== '0) $display("FAIL midreset_async: got=%h want 0", got); else pass++;
    cyc[1] = 0; stb[1] = 0; cyc[0] = 1; stb[0] = 1; adr[0] = 32'h44;
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (s_cyc !== 1'b0) $display("FAIL midreset_idle: s_cyc=%b want 0", s_cyc); else pass++;
    @(negedge clk);
    total++; if ({s_cyc, s_adr} !== {1'b1, 32'h44}) $display("FAIL midreset_regrant: cyc/adr=%b/%h want 1/00000044", s_cyc, s_adr); else pass++;
    tick();
    cyc[0] = 0; stb[0] = 0;
    tick();
  endtask

  // owner -1 means no grant; wt holds stalled cycles already seen by the current owner
  task automatic test_random();
    int own, lst, wt, w, g, bad;
    logic stall, er;
    logic [31:0] d0, d1;
    logic [138:0] exp;
    bad = 0;
    do_reset();
    own = -1; lst = 1; wt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0) cyc[m] = ~cyc[m];
        if ($urandom_range(0, 7) == 0) stb[m] = ~stb[m];
        we[m] = 1'($urandom); adr[m] = $urandom; wdat[m] = $urandom; sel[m] = 4'($urandom);
      end
      sack = ($urandom_range(0, 15) == 0);
      sdat = $urandom;
      @(negedge clk);
      stall = 0; er = 0; w = 0;
      if (own < 0) exp = '0;
      else begin
        g = own;
        stall = cyc[g] && stb[g] && !sack;
        w = stall ? wt + 1 : 0;
        er = stall && (w >= to - 1);
        d0 = (g == 0) ? sdat : 32'h0;
        d1 = (g == 1) ? sdat : 32'h0;
        exp = {cyc[g], stb[g] & ~er, we[g], adr[g], wdat[g], sel[g],
               d0, sack & (g == 0), er & (g == 0), d1, sack & (g == 1), er & (g == 1)};
      end
      total++;
      if (got !== exp) begin
        pass += 0;
        if (bad < 10) $display("FAIL random cycle %0d: got=%h want %h", i, got, exp);
        bad++;
      end else pass++;
      if (own >= 0) begin
        if (!cyc[own]) begin
          lst = own;
          own = cyc[1 - own] ? 1 - own : -1;
          wt = 0;
        end else wt = (stall && !er) ? w : 0;
      end else begin
        own = (cyc[0] && cyc[1]) ? 1 - lst : cyc[0] ? 0 : cyc[1] ? 1 : -1;
        wt = 0;
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_tie();
    test_isolation();
    test_watchdog();
    test_collision();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
